// File: rtl/rv_dmem_if.sv
// Data-memory bus between the MEM stage and rv_dmem: the load/store request,
// the combinational load result and fault flag, and the MMIO output port.
interface rv_dmem_if;
  logic [31:0] i_dmem_a;
  logic        i_dmem_we;
  logic [31:0] i_dmem_wd;
  logic [2:0]  i_dmem_bytectrl;
  logic [31:0] o_dmem_rd;
  logic        o_dmem_fault;
  logic [31:0] o_dmem_out;
  logic        o_dmem_out_valid;

  modport master (
    output i_dmem_a, i_dmem_we, i_dmem_wd, i_dmem_bytectrl,
    input  o_dmem_rd, o_dmem_fault, o_dmem_out, o_dmem_out_valid
  );

  modport slave (
    input  i_dmem_a, i_dmem_we, i_dmem_wd, i_dmem_bytectrl,
    output o_dmem_rd, o_dmem_fault, o_dmem_out, o_dmem_out_valid
  );
endinterface

// File: rtl/rv_dmem.sv
// RISC-V data memory: byte-addressable RAM with combinational little-endian
// loads and lane-masked stores, plus a 16-byte MMIO window holding a 64-bit
// cycle counter, an output port register and a sticky fault status bit.
module rv_dmem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic     i_dmem_clk,
  input  logic     i_dmem_rstn,
  rv_dmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // RAM array, intentionally without reset so it maps onto block RAM
  logic [31:0] ram [DEPTH_WORDS];

  logic [63:0] cnt;
  logic [31:0] out_reg;
  logic        out_vld;
  logic        sticky;

  logic          is_mmio;
  logic          fault;
  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [31:0]   wdata_rep;
  logic [3:0]    lane_be;
  logic          store_ok;
  logic          ram_we;
  logic          out_we;
  logic          status_clr;

  // Extract and extend the addressed byte/half/word from a 32-bit word.
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [1:0]  off,
                                              input logic [2:0]  bc);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (bc)
      3'b000:  return 32'(b);
      3'b100:  return {24'b0, b};
      3'b001:  return 32'(h);
      3'b101:  return {16'b0, h};
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  assign is_mmio = (bus.i_dmem_a[31:4] == MMIO_BASE[31:4]);
  assign widx    = bus.i_dmem_a[AW+1:2];

  // Fault on illegal size encodings and on misaligned half/word accesses
  always_comb begin
    case (bus.i_dmem_bytectrl)
      3'b000, 3'b100: fault = 1'b0;
      3'b001, 3'b101: fault = bus.i_dmem_a[0];
      3'b010:         fault = |bus.i_dmem_a[1:0];
      default:        fault = 1'b1;
    endcase
  end

  // Replicate store data across lanes and build the byte-enable mask
  always_comb begin
    lane_be   = 4'b0000;
    wdata_rep = bus.i_dmem_wd;
    case (bus.i_dmem_bytectrl)
      3'b000, 3'b100: begin
        lane_be   = 4'b0001 << bus.i_dmem_a[1:0];
        wdata_rep = {4{bus.i_dmem_wd[7:0]}};
      end
      3'b001, 3'b101: begin
        lane_be   = bus.i_dmem_a[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.i_dmem_wd[15:0]}};
      end
      3'b010:  lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  end

  // Select the 32-bit source word: RAM or one of the four MMIO registers
  always_comb begin
    rword = ram[widx];
    if (is_mmio) begin
      case (bus.i_dmem_a[3:2])
        2'd0:    rword = cnt[31:0];
        2'd1:    rword = cnt[63:32];
        2'd2:    rword = out_reg;
        default: rword = {31'b0, sticky};
      endcase
    end
  end

  assign bus.o_dmem_rd        = fault ? 32'h0 :
                                load_extend(rword, bus.i_dmem_a[1:0], bus.i_dmem_bytectrl);
  assign bus.o_dmem_fault     = fault;
  assign bus.o_dmem_out       = out_reg;
  assign bus.o_dmem_out_valid = out_vld;

  // Stores are suppressed while reset is asserted or the access faults
  assign store_ok   = i_dmem_rstn && bus.i_dmem_we && !fault;
  assign ram_we     = store_ok && !is_mmio;
  assign out_we     = store_ok && is_mmio && (bus.i_dmem_a[3:2] == 2'd2);
  assign status_clr = store_ok && is_mmio && (bus.i_dmem_a[3:2] == 2'd3) && bus.i_dmem_wd[0];

  // RAM write port with per-byte enables; reads see pre-write data this cycle
  always_ff @(posedge i_dmem_clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) ram[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  // MMIO registers: free-running counter, output port, valid pulse, sticky fault
  always_ff @(posedge i_dmem_clk) begin
    if (!i_dmem_rstn) begin
      cnt     <= 64'h0;
      out_reg <= 32'h0;
      out_vld <= 1'b0;
      sticky  <= 1'b0;
    end else begin
      cnt     <= cnt + 64'd1;
      out_vld <= out_we;
      if (out_we) begin
        for (int i = 0; i < 4; i++) begin
          if (lane_be[i]) out_reg[8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
      if (fault)           sticky <= 1'b1;
      else if (status_clr) sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_dmem.sv
// Testbench for rv_dmem: directed vector table, hand-written reset and
// counter-wrap sequences, and random traffic against a byte-level model.
module tb_rv_dmem;

  localparam logic [31:0] MB        = 32'hFFFF_0000;
  localparam int          RAM_BYTES = 1024 * 4;

  logic clk;
  logic rstn;

  rv_dmem_if bus();

  rv_dmem #(.DEPTH_WORDS(1024), .MMIO_BASE(MB)) dut (
    .i_dmem_clk (clk),
    .i_dmem_rstn(rstn),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  mbytes [RAM_BYTES];
  logic [63:0] mcnt;
  logic [31:0] mout;
  logic        mvld;
  logic        msticky;

  logic [31:0] last_rd;
  logic        last_flt;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
    logic [2:0]  bc;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_flt;
    logic        chk_out;
    logic [31:0] exp_out;
    logic        exp_vld;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] bc);
    case (bc)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Returns {fault, load value} from the model's current state
  function automatic logic [32:0] model_read(input logic [31:0] a, input logic [2:0] bc);
    int          n;
    int          off;
    int          base;
    logic [7:0]  lane [4];
    logic [31:0] w;
    logic [31:0] v;
    n   = size_of(bc);
    off = int'(a[1:0]);
    if (n == 0 || (off % n) != 0) return {1'b1, 32'h0};
    if (a[31:4] == MB[31:4]) begin
      case (a[3:2])
        2'd0:    w = mcnt[31:0];
        2'd1:    w = mcnt[63:32];
        2'd2:    w = mout;
        default: w = {31'b0, msticky};
      endcase
      for (int k = 0; k < 4; k++) lane[k] = w[8*k +: 8];
    end else begin
      base = int'(a % 32'(RAM_BYTES)) & ~3;
      for (int k = 0; k < 4; k++) lane[k] = mbytes[base + k];
    end
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(lane[off + k]) << (8 * k));
    if ((bc == 3'b000 || bc == 3'b001) && v[8*n-1] === 1'b1) v = v | (32'hFFFF_FFFF << (8 * n));
    return {1'b0, v};
  endfunction

  // Advance the model across one rising edge
  task automatic model_edge(input logic [31:0] a, input logic we, input logic [31:0] wd,
                            input logic [2:0] bc);
    logic [32:0] r;
    int          n;
    int          off;
    int          base;
    r    = model_read(a, bc);
    n    = size_of(bc);
    off  = int'(a[1:0]);
    base = int'(a % 32'(RAM_BYTES)) & ~3;
    if (!rstn) begin
      mcnt = 64'h0; mout = 32'h0; mvld = 1'b0; msticky = 1'b0;
      return;
    end
    mcnt = mcnt + 64'd1;
    mvld = 1'b0;
    if (r[32]) msticky = 1'b1;
    else if (we) begin
      if (a[31:4] == MB[31:4]) begin
        if (a[3:2] == 2'd2) begin
          for (int k = 0; k < n; k++) mout[8*(off+k) +: 8] = wd[8*k +: 8];
          mvld = 1'b1;
        end else if (a[3:2] == 2'd3 && wd[0]) begin
          msticky = 1'b0;
        end
      end else begin
        for (int k = 0; k < n; k++) mbytes[base + off + k] = wd[8*k +: 8];
      end
    end
  endtask

  // One bus cycle: drive, check combinational outputs, clock, check registers
  task automatic cycle(input logic [31:0] a, input logic we, input logic [31:0] wd,
                       input logic [2:0] bc);
    logic [32:0] m;
    bus.i_dmem_a        = a;
    bus.i_dmem_we       = we;
    bus.i_dmem_wd       = wd;
    bus.i_dmem_bytectrl = bc;
    #1;
    m        = model_read(a, bc);
    last_rd  = bus.o_dmem_rd;
    last_flt = bus.o_dmem_fault;
    check("model_fault", {31'b0, last_flt}, {31'b0, m[32]});
    if (!$isunknown(m[31:0])) check("model_rd", last_rd, m[31:0]);
    @(posedge clk);
    model_edge(a, we, wd, bc);
    #1;
    check("model_out", bus.o_dmem_out, mout);
    check("model_out_valid", {31'b0, bus.o_dmem_out_valid}, {31'b0, mvld});
  endtask

  task automatic add(input string nm, input logic [31:0] a, input logic we, input logic [31:0] wd,
                     input logic [2:0] bc, input logic chk_rd, input logic [31:0] exp_rd,
                     input logic exp_flt, input logic chk_out, input logic [31:0] exp_out,
                     input logic exp_vld);
    vec_t v;
    v.name = nm; v.a = a; v.we = we; v.wd = wd; v.bc = bc;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_flt = exp_flt;
    v.chk_out = chk_out; v.exp_out = exp_out; v.exp_vld = exp_vld;
    vecs.push_back(v);
  endtask

  logic [31:0] ra;
  logic [2:0]  rbc;
  logic        rwe;

  initial begin
    // Directed vectors: name, a, we, wd, bc, chk_rd, rd, fault, chk_out, out, valid
    add("sw_lane",   32'h10, 1, 32'h8877_6655, 3'b010, 0, 32'h0,         0, 0, 32'h0, 0);
    add("lb_13",     32'h13, 0, 32'h0,         3'b000, 1, 32'hFFFF_FF88, 0, 0, 32'h0, 0);
    add("lbu_13",    32'h13, 0, 32'h0,         3'b100, 1, 32'h0000_0088, 0, 0, 32'h0, 0);
    add("lh_12",     32'h12, 0, 32'h0,         3'b001, 1, 32'hFFFF_8877, 0, 0, 32'h0, 0);
    add("lhu_10",    32'h10, 0, 32'h0,         3'b101, 1, 32'h0000_6655, 0, 0, 32'h0, 0);
    add("sb_11",     32'h11, 1, 32'h0000_00AB, 3'b000, 1, 32'h0000_0066, 0, 0, 32'h0, 0);
    add("lw_sb",     32'h10, 0, 32'h0,         3'b010, 1, 32'h8877_AB55, 0, 0, 32'h0, 0);
    add("sh_12",     32'h12, 1, 32'h0000_1234, 3'b001, 1, 32'hFFFF_8877, 0, 0, 32'h0, 0);
    add("lw_sh",     32'h10, 0, 32'h0,         3'b010, 1, 32'h1234_AB55, 0, 0, 32'h0, 0);
    add("sw_20",     32'h20, 1, 32'h1111_1111, 3'b010, 0, 32'h0,         0, 0, 32'h0, 0);
    add("sw_mis",    32'h22, 1, 32'hDEAD_BEEF, 3'b010, 1, 32'h0,         1, 0, 32'h0, 0);
    add("lh_mis",    32'h21, 0, 32'h0,         3'b001, 1, 32'h0,         1, 0, 32'h0, 0);
    add("bc_011",    32'h20, 1, 32'hDEAD_BEEF, 3'b011, 1, 32'h0,         1, 0, 32'h0, 0);
    add("lw_20",     32'h20, 0, 32'h0,         3'b010, 1, 32'h1111_1111, 0, 0, 32'h0, 0);
    add("status_1",  MB+12,  0, 32'h0,         3'b010, 1, 32'h1,         0, 0, 32'h0, 0);
    add("status_cl", MB+12,  1, 32'h1,         3'b010, 1, 32'h1,         0, 0, 32'h0, 0);
    add("status_0",  MB+12,  0, 32'h0,         3'b010, 1, 32'h0,         0, 0, 32'h0, 0);
    add("sw_40_0",   32'h40, 1, 32'h0,         3'b010, 0, 32'h0,         0, 0, 32'h0, 0);
    add("sw_40_5",   32'h40, 1, 32'h5,         3'b010, 1, 32'h0,         0, 0, 32'h0, 0);
    add("lw_40",     32'h40, 0, 32'h0,         3'b010, 1, 32'h5,         0, 0, 32'h0, 0);
    add("out_wr",    MB+8,   1, 32'hCAFE_F00D, 3'b010, 1, 32'h0,         0, 1, 32'hCAFE_F00D, 1);
    add("out_rd",    MB+8,   0, 32'h0,         3'b010, 1, 32'hCAFE_F00D, 0, 1, 32'hCAFE_F00D, 0);
    add("out_b2b1",  MB+8,   1, 32'h1,         3'b010, 0, 32'h0,         0, 1, 32'h1,         1);
    add("out_b2b2",  MB+8,   1, 32'h2,         3'b010, 1, 32'h1,         0, 1, 32'h2,         1);
    add("out_sb9",   MB+9,   1, 32'h77,        3'b000, 1, 32'h0,         0, 1, 32'h0000_7702, 1);
    add("out_lw",    MB+8,   0, 32'h0,         3'b010, 1, 32'h0000_7702, 0, 1, 32'h0000_7702, 0);
    add("cnt_st",    MB+0,   1, 32'h0,         3'b010, 0, 32'h0,         0, 1, 32'h0000_7702, 0);

    // Reset entry: idle on STATUS reads
    rstn = 1'b0;
    bus.i_dmem_a = MB + 12; bus.i_dmem_we = 1'b0; bus.i_dmem_wd = 32'h0; bus.i_dmem_bytectrl = 3'b010;
    @(posedge clk); #1;
    model_edge(MB + 12, 1'b0, 32'h0, 3'b010);
    cycle(MB + 12, 1'b0, 32'h0, 3'b010);
    check("rst_out", bus.o_dmem_out, 32'h0);
    check("rst_valid", {31'b0, bus.o_dmem_out_valid}, 32'h0);
    cycle(MB + 0, 1'b0, 32'h0, 3'b010);
    check("cnt_in_reset", last_rd, 32'h0);
    rstn = 1'b1;
    cycle(MB + 0, 1'b0, 32'h0, 3'b010);
    check("cnt_first", last_rd, 32'h0);
    cycle(MB + 0, 1'b0, 32'h0, 3'b010);
    check("cnt_second", last_rd, 32'h1);

    // Directed table
    foreach (vecs[i]) begin
      cycle(vecs[i].a, vecs[i].we, vecs[i].wd, vecs[i].bc);
      if (vecs[i].chk_rd) begin
        check({vecs[i].name, "_rd"}, last_rd, vecs[i].exp_rd);
        check({vecs[i].name, "_fault"}, {31'b0, last_flt}, {31'b0, vecs[i].exp_flt});
      end
      if (vecs[i].chk_out) begin
        check({vecs[i].name, "_out"}, bus.o_dmem_out, vecs[i].exp_out);
        check({vecs[i].name, "_valid"}, {31'b0, bus.o_dmem_out_valid}, {31'b0, vecs[i].exp_vld});
      end
    end

    // Counter wrap from all-ones
    bus.i_dmem_a = MB + 0; bus.i_dmem_we = 1'b0; bus.i_dmem_wd = 32'h0; bus.i_dmem_bytectrl = 3'b010;
    force dut.cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    mcnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    check("cnt_preload", bus.o_dmem_rd, 32'hFFFF_FFFF);
    release dut.cnt;
    @(posedge clk);
    model_edge(MB + 0, 1'b0, 32'h0, 3'b010);
    #1;
    cycle(MB + 0, 1'b0, 32'h0, 3'b010);
    check("cnt_wrap_lo", last_rd, 32'h0);
    cycle(MB + 4, 1'b0, 32'h0, 3'b010);
    check("cnt_wrap_hi", last_rd, 32'h0);

    // Reset in the middle of traffic, with stores in the reset cycles
    cycle(MB + 0, 1'b0, 32'h0, 3'b111);
    rstn = 1'b0;
    cycle(MB + 8, 1'b1, 32'hFFFF_FFFF, 3'b010);
    cycle(32'h10, 1'b1, 32'h0, 3'b010);
    check("midrst_out", bus.o_dmem_out, 32'h0);
    check("midrst_valid", {31'b0, bus.o_dmem_out_valid}, 32'h0);
    cycle(MB + 0, 1'b0, 32'h0, 3'b010);
    check("midrst_cnt", last_rd, 32'h0);
    cycle(MB + 12, 1'b0, 32'h0, 3'b010);
    check("midrst_status", last_rd, 32'h0);
    cycle(MB + 8, 1'b0, 32'h0, 3'b010);
    check("midrst_out_rd", last_rd, 32'h0);
    rstn = 1'b1;
    cycle(32'h10, 1'b0, 32'h0, 3'b010);
    check("midrst_ram_kept", last_rd, 32'h1234_AB55);

    // Random traffic: seed a RAM region, then mix loads/stores, aliases, MMIO, faults
    for (int i = 0; i < 64; i++) cycle(32'h100 + 32'(4 * i), 1'b1, $urandom, 3'b010);
    for (int it = 0; it < 600; it++) begin
      rbc = 3'($urandom_range(0, 7));
      if ((rbc == 3'b011 || rbc == 3'b110 || rbc == 3'b111) && $urandom_range(0, 3) != 0) rbc = 3'b010;
      if ($urandom_range(0, 99) < 80)
        ra = (32'h100 + 32'($urandom_range(0, 255))) | (32'($urandom_range(0, 15)) << 12);
      else
        ra = MB + 32'($urandom_range(0, 15));
      rwe = 1'($urandom_range(0, 1));
      if (ra[31:4] == MB[31:4] && ra[3:2] == 2'd3) rwe = 1'b0;
      cycle(ra, rwe, $urandom, rbc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
